clint_axi_lite_master: RTL
==========================

CLINT_AXI_LITE_MASTER -- requirements
Module: clint_axi_lite_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64: width of request and AXI address.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64: data width; only 64 supported, with a simulation-time fatal check otherwise.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_i is the single clock and rst_ni is the asynchronous active-low reset.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active low
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  AXI_ADDR_WIDTH  byte address
- req_wdata_i  in  64  write data
- rsp_valid_o  out  1  response pulse
- rsp_rdata_o  out  64  read data
- rsp_err_o  out  1  error flag
- aw_addr_o  out  AXI_ADDR_WIDTH
- aw_valid_o  out  1
- aw_ready_i  in  1
- w_data_o  out  64
- w_strb_o  out  8
- w_valid_o  out  1
- w_ready_i  in  1
- b_resp_i  in  2
- b_valid_i  in  1
- b_ready_o  out  1
- ar_addr_o  out  AXI_ADDR_WIDTH
- ar_valid_o  out  1
- ar_ready_i  in  1
- r_data_i  in  64
- r_resp_i  in  2
- r_valid_i  in  1
- r_ready_o  out  1

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP.
REQ-006 IDLE: req_ready_o=1; command accepted when req_valid_i && req_ready_o; addr/we/wdata SHALL be captured in registers at acceptance.
REQ-007 Accepted command with req_addr_i[2:0]!=0 SHALL skip the bus and go to RESP with rsp_err_o=1 and rdata 0.
REQ-008 Aligned write: go to WRITE; aw_valid_o and w_valid_o SHALL assert the next cycle, with w_strb_o=8'hFF.
REQ-009 AW and W SHALL complete independently: each valid drops the cycle after its own handshake. Once both are done, the FSM SHALL go to WAIT_B; AW and W handshakes in the same cycle are legal.
REQ-010 WAIT_B: b_ready_o=1; on b_valid_i, go to RESP with rsp_err_o = (b_resp_i[1]==1).
REQ-011 Aligned read: READ asserts ar_valid_o until ar_ready_i, then moves to WAIT_R. WAIT_R: r_ready_o=1; on r_valid_i, r_data_i SHALL be captured and the FSM goes to RESP with rsp_err_o = r_resp_i[1].
REQ-012 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; rsp_rdata_o and rsp_err_o SHALL remain stable until the next response.
REQ-013 Only one outstanding transaction; req_ready_o=0 in every state except IDLE.
REQ-014 AXI valids, once asserted, SHALL NOT drop before the handshake; addr and data outputs stable while valid.
REQ-015 b_ready_o and r_ready_o SHALL be 0 outside WAIT_B and WAIT_R; b_valid_i and r_valid_i arriving then are ignored.
REQ-016 Minimum latency: write with all readies high = accept cycle + 3 cycles to rsp_valid_o; read = accept + 3.
REQ-017 Write data to a 32-bit register (msip) SHALL be passed unmodified; word-lane placement is the requester's responsibility.

Reset
REQ-018 On rst_ni low, the FSM SHALL go to IDLE and all valid/ready outputs SHALL be 0 except req_ready_o=1; rsp_rdata_o=0 and rsp_err_o=0; captured registers cleared.
REQ-019 Reset mid-transaction SHALL abandon it without a response; no valid SHALL be asserted in the first cycle after release.

Verification
REQ-020 Read at 0xBFF8 with slave returning r_data=64'h0000_0000_0000_1234 and r_resp=0 -> one rsp_valid_o pulse with rsp_rdata_o=64'h1234 and rsp_err_o=0.
REQ-021 Write 0x4000 with data 64'hFFFF_FFFF_FFFF_FFFF, with aw_ready delayed 3 cycles and w_ready immediate -> w_valid drops first, aw held 3 cycles, then b handshake, then rsp_err_o=0.
REQ-022 Write with b_resp=2'b10 -> rsp_err_o=1; read with r_resp=2'b11 -> rsp_err_o=1.
REQ-023 Request to address 0x0004 (misaligned by 4) -> no AXI valid asserted, rsp_valid_o two cycles after accept, rsp_err_o=1.
REQ-024 Back-to-back requests with req_valid_i held high -> second accepted only after the rsp pulse; never two outstanding.
REQ-025 rst_ni asserted during WAIT_R -> all valids 0, req_ready_o=1, no rsp_valid_o; next read completes normally.

Source files
------------

// File: rtl/clint_axi_lite_master.sv
// clint_axi_lite_master
//   Converts single-beat CLINT register requests into AXI-Lite transactions.
//   Only one transaction is outstanding at a time. Misaligned requests never
//   reach the bus and are answered with an error.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       command handshake (ready only while idle)
//   req_we_i, req_addr_i,
//   req_wdata_i                   command: direction, byte address, write data
//   rsp_valid_o                   one-cycle response pulse
//   rsp_rdata_o, rsp_err_o        response data/error, held until next response
//   aw_*/w_*/b_*                  AXI-Lite write channels (master side)
//   ar_*/r_*                      AXI-Lite read channels (master side)
module clint_axi_lite_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [63:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    output logic [63:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [AXI_ADDR_WIDTH-1:0] aw_addr_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [63:0]               w_data_o,
    output logic [7:0]                w_strb_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    input  logic [1:0]                b_resp_i,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    output logic [AXI_ADDR_WIDTH-1:0] ar_addr_o,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    input  logic [63:0]               r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o
);

    if (AXI_DATA_WIDTH != 64) begin : g_data_width_check
        $fatal(1, "clint_axi_lite_master: only AXI_DATA_WIDTH=64 is supported");
    end

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ,
        WAIT_R,
        RESP
    } state_e;

    state_e                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [63:0]               wdata_q;
    logic                      req_ready_q;
    logic                      aw_valid_q;
    logic                      w_valid_q;
    logic                      b_ready_q;
    logic                      ar_valid_q;
    logic                      r_ready_q;
    logic                      rsp_valid_q;
    logic [63:0]               rsp_rdata_q;
    logic                      rsp_err_q;

    // A channel is finished once its valid is gone or it handshakes this cycle.
    logic aw_done;
    logic w_done;
    assign aw_done = !aw_valid_q || aw_ready_i;
    assign w_done  = !w_valid_q  || w_ready_i;

    // Only the SLVERR/DECERR bit of the response codes matters.
    logic unused_resp_lsb;
    assign unused_resp_lsb = b_resp_i[0] ^ r_resp_i[0];

    // The transfer direction is captured by the state itself (WRITE vs READ).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        req_ready_q <= 1'b0;
                        if (req_addr_i[2:0] != 3'b000) begin
                            state_q <= RESP;
                        end else if (req_we_i) begin
                            state_q    <= WRITE;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                        end else begin
                            state_q    <= READ;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (aw_valid_q && aw_ready_i) aw_valid_q <= 1'b0;
                    if (w_valid_q && w_ready_i)   w_valid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        state_q   <= WAIT_B;
                        b_ready_q <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (b_valid_i) begin
                        state_q     <= RESP;
                        b_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= b_resp_i[1];
                    end
                end
                READ: begin
                    if (ar_ready_i) begin
                        state_q    <= WAIT_R;
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                    end
                end
                WAIT_R: begin
                    if (r_valid_i) begin
                        state_q     <= RESP;
                        r_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= r_data_i;
                        rsp_err_q   <= r_resp_i[1];
                    end
                end
                RESP: begin
                    // Bus paths arrive with the pulse already raised. A
                    // misaligned request arrives without it, so RESP spends
                    // one extra cycle raising the error pulse first.
                    if (rsp_valid_q) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign aw_addr_o   = addr_q;
    assign aw_valid_o  = aw_valid_q;
    assign w_data_o    = wdata_q;
    assign w_strb_o    = 8'hFF;
    assign w_valid_o   = w_valid_q;
    assign b_ready_o   = b_ready_q;
    assign ar_addr_o   = addr_q;
    assign ar_valid_o  = ar_valid_q;
    assign r_ready_o   = r_ready_q;

endmodule
